config_loader: RTL
==================

// Module: config_loader
// PURPOSE
//   Writer side of the fabric configuration interface: receives the bitstream as a word stream over
//   a valid/ready handshake and deserialises it into a shadow register. It checks a trailing XOR
//   checksum, then commits the bits to the parallel config bus that feeds the logic columns.
//   Holds the fabric in reset (fabric_nreset low) until a good bitstream is committed.
// PARAMETERS
//   CONFIG_WIDTH  438  width of the parallel config bus driven into the fabric
//   WORD_WIDTH    8    bitstream word width
//   (derived) NUM_WORDS = ceil(CONFIG_WIDTH/WORD_WIDTH) = 55; SHADOW_W = NUM_WORDS*WORD_WIDTH = 440
// PORTS
//   clock          in   1             single clock, all logic on rising edge
//   reset          in   1             synchronous, active-high
//   start          in   1             begin load; sampled only in IDLE, DONE, ERROR
//   data_in        in   WORD_WIDTH    bitstream word
//   data_valid     in   1             data_in valid
//   data_ready     out  1             loader accepts a word this cycle
//   config_out     out  CONFIG_WIDTH  committed configuration to fabric
//   fabric_nreset  out  1             active-low reset to fabric; high only in DONE
//   busy           out  1             state is LOAD or CHECK
//   done           out  1             good bitstream committed
//   error          out  1             checksum mismatch on last load
// BEHAVIOUR
//   Reset: state=IDLE, config_out=0, shadow=0, word counter=0, checksum acc=0, fabric_nreset=0,
//     done=0, error=0, busy=0, data_ready=0. Reset mid-load aborts the load with no commit.
//   Handshake: a word transfers on a rising edge where data_valid&&data_ready. data_ready is
//     decoded from registered state only (no combinational path from data_valid).
//   IDLE : data_ready=0, valid words ignored. start -> LOAD, counter=0, acc=0.
//   LOAD : data_ready=1. Per transfer: shadow <= {data_in, shadow[SHADOW_W-1:WORD_WIDTH]};
//     acc <= acc ^ data_in; counter++. Transfer with counter==NUM_WORDS-1 -> CHECK.
//     After all words, word k occupies shadow[k*W +: W]. start ignored.
//   CHECK: data_ready=1. Next transfer is the checksum word. data_in==acc -> config_out <=
//     shadow[CONFIG_WIDTH-1:0], -> DONE; else -> ERROR with config_out unchanged.
//     Padding bits of the last word (shadow[SHADOW_W-1:CONFIG_WIDTH]) are in the checksum but
//     are discarded on commit. start ignored.
//   DONE : done=1, fabric_nreset=1, data_ready=0. start -> LOAD (reconfigure).
//   ERROR: error=1, fabric_nreset=0, data_ready=0. start -> LOAD.
//   All outputs are registered or decoded from state. config_out, done and fabric_nreset update
//     on the same edge, one cycle after the checksum transfer edge.
//   Reconfigure: leaving DONE/ERROR drops done, error and fabric_nreset on the next edge.
//     config_out keeps its old value until the next successful commit.
//   Gaps in data_valid stall progress. There is no timeout. Counter width is clog2(NUM_WORDS).
// TESTING
//   1 Nominal: start, words k=0..54 (data_in=k), checksum 0x37 -> done=1, fabric_nreset=1,
//     config_out[7:0]=8'h00, [15:8]=8'h01, [437:432]=6'h36. Commit lands 1 cycle after the checksum.
//   2 Bad checksum: same words, checksum 0x38 -> error=1, done=0, fabric_nreset=0,
//     config_out remains all-zero.
//   3 Backpressure and gaps: randomly deassert data_valid during test 1 -> identical config_out.
//     No word is counted twice. busy=1 throughout.
//   4 Reset mid-load: assert reset after word 20 -> next cycle state IDLE and all outputs at reset
//     values. A fresh test 1 sequence then completes correctly.
//   5 Reconfigure: from DONE of test 1, start, load all 0xFF words, checksum 0xFF
//     (55 words, odd count) -> fabric_nreset low during load, old config_out held until commit,
//     then config_out all ones.
//   6 Idle/ignored inputs: data_valid pulses in IDLE and start pulses during LOAD/CHECK ->
//     data_ready stays 0 in IDLE, no state or counter change.

Source files
------------

// File: rtl/config_loader_if.sv
// Word-stream handshake between a bitstream source and the configuration loader.
interface config_loader_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic [WORD_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/config_loader.sv
// Bitstream deserialiser: shifts words into a shadow register, checks a trailing XOR
// checksum and commits the result to the fabric config bus, releasing fabric reset on success.
module config_loader #(
  parameter int unsigned CONFIG_WIDTH = 438,
  parameter int unsigned WORD_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  config_loader_if.slave          bus,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    fabric_nreset,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int unsigned NUM_WORDS = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned SHADOW_W  = NUM_WORDS * WORD_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, state_next;

  logic [SHADOW_W-1:0]   shadow;
  logic [WORD_WIDTH-1:0] acc;
  logic [CNT_W-1:0]      count;

  logic xfer;
  logic last_word;
  logic sum_ok;
  logic can_start;

  assign xfer      = bus.data_valid && bus.data_ready;
  assign last_word = (count == CNT_W'(NUM_WORDS - 1));
  assign sum_ok    = (bus.data_in == acc);
  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LOAD;
      S_LOAD:                  if (xfer && last_word) state_next = S_CHECK;
      S_CHECK:                 if (xfer) state_next = sum_ok ? S_DONE : S_ERROR;
      default:                 state_next = S_IDLE;
    endcase
  end

  // Status outputs are pure state decodes, so data_ready never depends on data_valid.
  always_comb begin
    bus.data_ready = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    fabric_nreset  = 1'b0;
    unique case (state)
      S_LOAD, S_CHECK: begin
        bus.data_ready = 1'b1;
        busy           = 1'b1;
      end
      S_DONE: begin
        done          = 1'b1;
        fabric_nreset = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  // Words enter at the top and shift down, so word k ends at shadow[k*W +: W].
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow     <= '0;
      acc        <= '0;
      count      <= '0;
      config_out <= '0;
    end else begin
      if (can_start && start) begin
        count <= '0;
        acc   <= '0;
      end
      if (state == S_LOAD && xfer) begin
        shadow <= {bus.data_in, shadow[SHADOW_W-1:WORD_WIDTH]};
        acc    <= acc ^ bus.data_in;
        count  <= count + CNT_W'(1);
      end
      if (state == S_CHECK && xfer && sum_ok)
        config_out <= shadow[CONFIG_WIDTH-1:0];
    end
  end

endmodule
